// File: rtl/gemm_tile_packer_if.sv
// Stream-in / SRAM-write bundle of the GeMM tile packer.
//   in_data_i/in_valid_i/in_ready_o : element-serial signed operand stream
//   sram_addr_o/sram_wdata_o/sram_we_o : wide tile-word SRAM write port
// slave  : the packer (consumes the stream, drives the SRAM port)
// master : the stream producer / SRAM-side observer
interface gemm_tile_packer_if #(
  parameter int unsigned InDataWidth = 8,
  parameter int unsigned AddrWidth   = 16,
  parameter int unsigned WordWidth   = 128
);
  logic signed [InDataWidth-1:0] in_data_i;
  logic                          in_valid_i;
  logic                          in_ready_o;
  logic [AddrWidth-1:0]          sram_addr_o;
  logic [WordWidth-1:0]          sram_wdata_o;
  logic                          sram_we_o;

  modport master (
    output in_data_i, in_valid_i,
    input  in_ready_o, sram_addr_o, sram_wdata_o, sram_we_o
  );

  modport slave (
    input  in_data_i, in_valid_i,
    output in_ready_o, sram_addr_o, sram_wdata_o, sram_we_o
  );
endinterface

// File: rtl/gemm_tile_packer.sv
// Packs TileRows*TileCols consecutive stream elements into one wide tile
// word and writes one word per SRAM address starting at a base address.
//   clk_i, rst_ni     : clock, synchronous active-low reset
//   start_i           : start a transfer (sampled only in IDLE)
//   base_addr_i       : first SRAM address, latched with start_i
//   num_tiles_i       : number of tile words, latched with start_i
//   busy_o            : transfer in progress (FILL/WRITE/DONE)
//   done_o            : one-cycle completion pulse
//   bus (slave)       : element stream in, SRAM write port out
// Stream element j lands in word slice j; the packer is layout-agnostic.
module gemm_tile_packer #(
  parameter int unsigned InDataWidth = 8,
  parameter int unsigned AddrWidth   = 16,
  parameter int unsigned TileRows    = 4,
  parameter int unsigned TileCols    = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [AddrWidth-1:0] base_addr_i,
  input  logic [AddrWidth-1:0] num_tiles_i,
  output logic                 busy_o,
  output logic                 done_o,
  gemm_tile_packer_if.slave    bus
);

  localparam int unsigned TileElems = TileRows * TileCols;
  localparam int unsigned WordWidth = InDataWidth * TileElems;
  localparam int unsigned ElemCntW  = (TileElems > 1) ? $clog2(TileElems) : 1;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    WRITE,
    DONE
  } state_e;

  state_e                state_q, state_d;
  logic [ElemCntW-1:0]   elem_cnt_q, elem_cnt_d;
  logic [AddrWidth-1:0]  tile_cnt_q, tile_cnt_d;
  logic [AddrWidth-1:0]  base_q, base_d;
  logic [AddrWidth-1:0]  num_q, num_d;
  logic [WordWidth-1:0]  buf_q, buf_d;
  logic [AddrWidth-1:0]  addr_q, addr_d;
  logic [WordWidth-1:0]  wdata_q, wdata_d;

  always_comb begin
    state_d    = state_q;
    elem_cnt_d = elem_cnt_q;
    tile_cnt_d = tile_cnt_q;
    base_d     = base_q;
    num_d      = num_q;
    buf_d      = buf_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          base_d     = base_addr_i;
          num_d      = num_tiles_i;
          elem_cnt_d = '0;
          tile_cnt_d = '0;
          state_d    = (num_tiles_i != '0) ? FILL : DONE;
        end
      end
      FILL: begin
        if (bus.in_valid_i) begin
          for (int unsigned j = 0; j < TileElems; j++) begin
            if (elem_cnt_q == ElemCntW'(j)) begin
              buf_d[j*InDataWidth +: InDataWidth] = bus.in_data_i;
            end
          end
          if (elem_cnt_q == ElemCntW'(TileElems - 1)) begin
            elem_cnt_d = '0;
            state_d    = WRITE;
            // Word and address are captured on entry to WRITE so the SRAM
            // port holds its last values outside WRITE while buf_q refills.
            wdata_d    = buf_d;
            addr_d     = base_q + tile_cnt_q;
          end else begin
            elem_cnt_d = elem_cnt_q + ElemCntW'(1);
          end
        end
      end
      WRITE: begin
        if (tile_cnt_q == num_q - AddrWidth'(1)) begin
          state_d = DONE;
        end else begin
          tile_cnt_d = tile_cnt_q + AddrWidth'(1);
          state_d    = FILL;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      elem_cnt_q <= '0;
      tile_cnt_q <= '0;
      base_q     <= '0;
      num_q      <= '0;
      buf_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      elem_cnt_q <= elem_cnt_d;
      tile_cnt_q <= tile_cnt_d;
      base_q     <= base_d;
      num_q      <= num_d;
      buf_q      <= buf_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

  assign bus.in_ready_o   = (state_q == FILL);
  assign bus.sram_we_o    = (state_q == WRITE);
  assign bus.sram_addr_o  = addr_q;
  assign bus.sram_wdata_o = wdata_q;
  assign busy_o           = (state_q != IDLE);
  assign done_o           = (state_q == DONE);

endmodule
